frame_buffer_rect_fill: RTL and testbench

- Drawing engine that writes solid-colour axis-aligned rectangles into the downscaled frame buffer.
- Drives the write side of the same 32-bit byte-addressed BRAM port type the scan-out path reads.
- Addressing is compatible with scan-out: byte address = pixel index = y*H_RES + x, byte lane = addr[1:0], one 8-bit RGB332 pixel per byte.
- Accepts one command at a time over a valid/ready handshake and emits at most one BRAM write per clock, merging aligned groups of 4 pixels into full-word writes.

---
 rtl/frame_buffer_rect_fill.sv | 178 +++++++++++++++++
 tb/tb_frame_buffer_rect_fill.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_rect_fill.sv
// Solid-colour rectangle fill engine for the downscaled RGB332 frame buffer.
// Generates row-major BRAM writes, merging aligned 4-pixel groups into word writes.
module frame_buffer_rect_fill #(
   parameter int H_RES            = 400,
   parameter int V_RES            = 300,
   parameter int H_NUM_BITS       = 9,
   parameter int V_NUM_BITS       = 9,
   parameter int BUFFER_ADDR_BITS = 17,
   parameter int COLOR_WIDTH      = 8
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [H_NUM_BITS-1:0]   cmd_x,
   input  logic [V_NUM_BITS-1:0]   cmd_y,
   input  logic [H_NUM_BITS:0]     cmd_w,
   input  logic [V_NUM_BITS:0]     cmd_h,
   input  logic [COLOR_WIDTH-1:0]  cmd_color,
   output logic                    busy,
   output logic                    done,
   output logic [31:0]             buffer_addr,
   output logic [31:0]             buffer_din,
   input  logic [31:0]             buffer_dout,
   output logic                    buffer_en,
   output logic                    buffer_rst,
   output logic [3:0]              buffer_we
);

   localparam int XW = H_NUM_BITS + 1;
   localparam int YW = V_NUM_BITS + 1;
   localparam int AW = BUFFER_ADDR_BITS;
   localparam logic [XW-1:0] H_RES_X = XW'(H_RES);
   localparam logic [YW-1:0] V_RES_Y = YW'(V_RES);
   localparam logic [XW:0]   H_RES_S = (XW+1)'(H_RES);
   localparam logic [YW:0]   V_RES_S = (YW+1)'(V_RES);
   localparam logic [AW-1:0] H_RES_A = AW'(H_RES);

   typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;
   state_t state_reg, state_next;

   logic [XW-1:0]          x0_reg, x_end_reg, cur_x_reg;
   logic [YW-1:0]          y_end_reg, cur_y_reg;
   logic [AW-1:0]          row_base_reg;
   logic [COLOR_WIDTH-1:0] color_reg;

   logic                   ready_reg, busy_reg, done_reg, en_reg;
   logic                   ready_next, busy_next, done_next, en_next;
   logic [3:0]             we_reg, we_next;
   logic [AW-1:0]          addr_reg, addr_next;
   logic [31:0]            din_reg, din_next;

   logic          accept, cmd_empty;
   logic [XW:0]   sum_x;
   logic [YW:0]   sum_y;
   logic [XW-1:0] clip_x;
   logic [YW-1:0] clip_y;

   logic          issue, word, row_end;
   logic [XW-1:0] src_x, span, adv_x, step_x;
   logic [YW-1:0] step_y;
   logic [AW-1:0] y_base, src_base, wr_addr, step_base;
   logic [3:0]    wr_we;
   logic [31:0]   fill_word;

   logic unused_dout;
   assign unused_dout = ^buffer_dout;

   genvar gi;
   generate
      for (gi = 0; gi < 32 / COLOR_WIDTH; gi++) begin : g_lane
         assign fill_word[gi*COLOR_WIDTH +: COLOR_WIDTH] = color_reg;
      end
   endgenerate

   // Far edges are clipped on one-bit-wider sums so large widths never wrap.
   assign accept    = cmd_valid && (state_reg == IDLE);
   assign sum_x     = {2'b00, cmd_x} + {1'b0, cmd_w};
   assign sum_y     = {2'b00, cmd_y} + {1'b0, cmd_h};
   assign clip_x    = (sum_x > H_RES_S) ? H_RES_X : sum_x[XW-1:0];
   assign clip_y    = (sum_y > V_RES_S) ? V_RES_Y : sum_y[YW-1:0];
   assign cmd_empty = (cmd_w == '0) || (cmd_h == '0) ||
                      ({1'b0, cmd_x} >= H_RES_X) || ({1'b0, cmd_y} >= V_RES_Y);

   // The generator runs one step ahead of the port: SETUP already issues the
   // first write so it lands on the registered outputs as FILL begins.
   assign y_base    = AW'(cur_y_reg) * H_RES_A;
   assign src_x     = (state_reg == SETUP) ? x0_reg : cur_x_reg;
   assign src_base  = (state_reg == SETUP) ? y_base : row_base_reg;
   assign issue     = (state_reg == SETUP) ||
                      ((state_reg == FILL) && (cur_y_reg != y_end_reg));
   assign span      = x_end_reg - src_x;
   assign word      = (src_x[1:0] == 2'b00) && (span >= XW'(4));
   assign wr_addr   = src_base + AW'(src_x);
   assign wr_we     = word ? 4'b1111 : (4'b0001 << wr_addr[1:0]);
   assign adv_x     = src_x + (word ? XW'(4) : XW'(1));
   assign row_end   = (adv_x == x_end_reg);
   assign step_x    = row_end ? x0_reg : adv_x;
   assign step_y    = row_end ? cur_y_reg + YW'(1) : cur_y_reg;
   assign step_base = row_end ? src_base + H_RES_A : src_base;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (accept) state_next = cmd_empty ? DONE : SETUP;
         SETUP:   state_next = FILL;
         FILL:    if (!issue) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      ready_next = (state_next == IDLE);
      busy_next  = (state_next != IDLE);
      done_next  = (state_next == DONE);
      en_next    = issue;
      we_next    = issue ? wr_we : 4'b0000;
      addr_next  = issue ? wr_addr : addr_reg;
      din_next   = issue ? fill_word : din_reg;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ready_reg    <= 1'b1;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
         en_reg       <= 1'b0;
         we_reg       <= 4'b0000;
         addr_reg     <= '0;
         din_reg      <= '0;
         x0_reg       <= '0;
         x_end_reg    <= '0;
         y_end_reg    <= '0;
         cur_x_reg    <= '0;
         cur_y_reg    <= '0;
         row_base_reg <= '0;
         color_reg    <= '0;
      end else begin
         ready_reg <= ready_next;
         busy_reg  <= busy_next;
         done_reg  <= done_next;
         en_reg    <= en_next;
         we_reg    <= we_next;
         addr_reg  <= addr_next;
         din_reg   <= din_next;
         if (accept) begin
            x0_reg    <= {1'b0, cmd_x};
            cur_y_reg <= {1'b0, cmd_y};
            x_end_reg <= clip_x;
            y_end_reg <= clip_y;
            color_reg <= cmd_color;
         end else if (issue) begin
            cur_x_reg    <= step_x;
            cur_y_reg    <= step_y;
            row_base_reg <= step_base;
         end
      end
   end

   assign cmd_ready   = ready_reg;
   assign busy        = busy_reg;
   assign done        = done_reg;
   assign buffer_en   = en_reg;
   assign buffer_we   = we_reg;
   assign buffer_addr = {{(32-AW){1'b0}}, addr_reg};
   assign buffer_din  = din_reg;
   assign buffer_rst  = 1'b0;

endmodule

// File: tb/tb_frame_buffer_rect_fill.sv
// Bench for frame_buffer_rect_fill: directed and random rectangles checked
// against a write-list model and a pixel-level frame buffer model.
module tb_frame_buffer_rect_fill;

   localparam int HR   = 400;
   localparam int VR   = 300;
   localparam int NPIX = HR * VR;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [8:0]  cmd_x = '0;
   logic [8:0]  cmd_y = '0;
   logic [9:0]  cmd_w = '0;
   logic [9:0]  cmd_h = '0;
   logic [7:0]  cmd_color = '0;
   logic        busy, done;
   logic [31:0] buffer_addr, buffer_din;
   logic [31:0] buffer_dout = '0;
   logic        buffer_en, buffer_rst;
   logic [3:0]  buffer_we;

   frame_buffer_rect_fill dut (
      .clk(clk), .resetn(resetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
      .cmd_color(cmd_color), .busy(busy), .done(done),
      .buffer_addr(buffer_addr), .buffer_din(buffer_din),
      .buffer_dout(buffer_dout), .buffer_en(buffer_en),
      .buffer_rst(buffer_rst), .buffer_we(buffer_we)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) buffer_dout <= $urandom();

   logic [31:0] mon_addr[$];
   logic [3:0]  mon_we[$];
   logic [31:0] mon_din[$];
   int          mon_cyc[$];

   always @(negedge clk) begin
      if (resetn === 1'b1 && buffer_en !== 1'b0) begin
         mon_addr.push_back(buffer_addr);
         mon_we.push_back(buffer_we);
         mon_din.push_back(buffer_din);
         mon_cyc.push_back(cyc);
      end
   end

   logic [7:0] act_mem [NPIX];
   logic [7:0] exp_mem [NPIX];
   int         exp_waddr[$];
   logic [3:0] exp_wwe[$];
   int         checks = 0;
   int         errors = 0;
   int         oob = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   // Write list derived from the pixel span of each clipped row.
   function automatic void build_expected(input int x, input int y, input int w, input int h);
      int xe, ye, xx, a;
      exp_waddr.delete();
      exp_wwe.delete();
      if (w == 0 || h == 0 || x >= HR || y >= VR) return;
      xe = imin(x + w, HR);
      ye = imin(y + h, VR);
      for (int yy = y; yy < ye; yy++) begin
         xx = x;
         while (xx < xe) begin
            a = yy * HR + xx;
            if (xx % 4 == 0 && xe - xx >= 4) begin
               exp_waddr.push_back(a);
               exp_wwe.push_back(4'b1111);
               xx += 4;
            end else begin
               exp_waddr.push_back(a);
               exp_wwe.push_back(4'(1 << (a % 4)));
               xx += 1;
            end
         end
      end
   endfunction

   function automatic void fill_exp_mem(input int x, input int y, input int w, input int h,
                                        input logic [7:0] c);
      for (int yy = y; yy < imin(y + h, VR); yy++)
         for (int xx = x; xx < imin(x + w, HR); xx++)
            exp_mem[yy * HR + xx] = c;
   endfunction

   function automatic void apply_exp_prefix(input int n, input logic [7:0] c);
      for (int i = 0; i < n && i < exp_waddr.size(); i++)
         for (int l = 0; l < 4; l++)
            if (exp_wwe[i][l] && (exp_waddr[i] & ~3) + l < NPIX)
               exp_mem[(exp_waddr[i] & ~3) + l] = c;
   endfunction

   task automatic start_cmd(input string tag, input int x, input int y, input int w,
                            input int h, input logic [7:0] c, input bit keep,
                            output int acc);
      cmd_x = 9'(x); cmd_y = 9'(y); cmd_w = 10'(w); cmd_h = 10'(h); cmd_color = c;
      cmd_valid = 1'b1;
      acc = -1;
      for (int k = 0; k < 3000; k++) begin
         if (cmd_ready === 1'b1) begin
            acc = cyc;
            break;
         end
         @(negedge clk);
      end
      check({tag, " accepted"}, 64'(acc >= 0), 64'd1);
      @(negedge clk);
      if (!keep) cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag, output int done_cyc);
      int leak = 0;
      done_cyc = -1;
      for (int k = 0; k < 20000; k++) begin
         if (done === 1'b1) begin
            done_cyc = cyc;
            break;
         end
         if (cmd_ready !== 1'b0 || busy !== 1'b1) leak++;
         @(negedge clk);
      end
      check({tag, " ready low while busy"}, 64'(leak), 64'd0);
      check({tag, " done seen"}, 64'(done_cyc >= 0), 64'd1);
      check({tag, " en low at done"}, 64'(buffer_en), 64'd0);
      @(negedge clk);
      check({tag, " ready after done"}, 64'({cmd_ready, done, busy}), 64'b100);
   endtask

   task automatic drain(input string tag, input logic [7:0] c, input int acc,
                        input int done_cyc, input bit aborted, output int n);
      int    bad = 0;
      string detail = "";
      int    base;
      n = mon_addr.size();
      for (int i = 0; i < n; i++) begin
         if (i >= exp_waddr.size() || mon_addr[i] !== 32'(exp_waddr[i]) ||
             mon_we[i] !== exp_wwe[i] || mon_din[i] !== {4{c}}) begin
            if (bad == 0)
               detail = $sformatf(" first bad write %0d addr %0d we %b din %h", i,
                                  mon_addr[i], mon_we[i], mon_din[i]);
            bad++;
         end
         base = int'(mon_addr[i]) & ~3;
         for (int l = 0; l < 4; l++)
            if (mon_we[i][l]) begin
               if (base + l >= NPIX) oob++;
               else act_mem[base + l] = mon_din[i][8*l +: 8];
            end
      end
      check({tag, " write contents", detail}, 64'(bad), 64'd0);
      if (!aborted) begin
         check({tag, " write count"}, 64'(n), 64'(exp_waddr.size()));
         if (n > 0) begin
            check({tag, " first write latency"}, 64'(mon_cyc[0] - acc), 64'd2);
            check({tag, " done after last write"}, 64'(done_cyc - mon_cyc[n-1]), 64'd1);
            check({tag, " no bubbles"}, 64'(mon_cyc[n-1] - mon_cyc[0]), 64'(n - 1));
         end else begin
            check({tag, " empty done latency"}, 64'(done_cyc - acc), 64'd1);
         end
      end
      mon_addr.delete(); mon_we.delete(); mon_din.delete(); mon_cyc.delete();
   endtask

   task automatic check_mem(input string tag);
      int diffs = 0;
      for (int i = 0; i < NPIX; i++)
         if (act_mem[i] !== exp_mem[i]) diffs++;
      check({tag, " frame buffer"}, 64'(diffs), 64'd0);
      check({tag, " out of range writes"}, 64'(oob), 64'd0);
   endtask

   task automatic run_cmd(input string tag, input int x, input int y, input int w,
                          input int h, input logic [7:0] c);
      int acc, dc, n;
      build_expected(x, y, w, h);
      fill_exp_mem(x, y, w, h, c);
      start_cmd(tag, x, y, w, h, c, 1'b0, acc);
      wait_done(tag, dc);
      drain(tag, c, acc, dc, 1'b0, n);
      check_mem(tag);
      $display("cmd %s: x=%0d y=%0d w=%0d h=%0d color=%h accept@%0d done@%0d writes=%0d",
               tag, x, y, w, h, c, acc, dc, n);
   endtask

   initial begin
      int acc_a, acc_b, dc_a, dc_b, n;
      int rx, ry, rw, rh;
      logic [7:0] rc;

      for (int i = 0; i < NPIX; i++) begin
         act_mem[i] = 8'h00;
         exp_mem[i] = 8'h00;
      end

      repeat (3) @(negedge clk);
      check("reset ready", 64'(cmd_ready), 64'd1);
      check("reset busy", 64'(busy), 64'd0);
      check("reset done", 64'(done), 64'd0);
      check("reset en", 64'(buffer_en), 64'd0);
      check("reset we", 64'(buffer_we), 64'd0);
      check("reset addr", 64'(buffer_addr), 64'd0);
      check("reset din", 64'(buffer_din), 64'd0);
      check("reset rst", 64'(buffer_rst), 64'd0);
      resetn = 1'b1;
      @(negedge clk);

      run_cmd("1x1 origin", 0, 0, 1, 1, 8'hE3);
      run_cmd("row x1 y2 w8", 1, 2, 8, 1, 8'h1C);
      run_cmd("clip corner", 398, 299, 10, 10, 8'h55);
      run_cmd("empty w0", 10, 10, 0, 5, 8'hAA);
      run_cmd("empty x400", 400, 10, 5, 5, 8'hAB);
      run_cmd("empty h0", 7, 7, 9, 0, 8'hAC);
      run_cmd("right edge word", 396, 5, 4, 2, 8'h3C);
      run_cmd("full row", 0, 150, 400, 1, 8'h92);
      run_cmd("bottom clip", 13, 298, 11, 5, 8'h6D);

      // Back-to-back: valid stays high, second command waits for the first to finish.
      build_expected(20, 40, 13, 3);
      fill_exp_mem(20, 40, 13, 3, 8'hC1);
      start_cmd("b2b first", 20, 40, 13, 3, 8'hC1, 1'b1, acc_a);
      cmd_x = 9'd5; cmd_y = 9'd41; cmd_w = 10'd6; cmd_h = 10'd2; cmd_color = 8'h07;
      wait_done("b2b first", dc_a);
      drain("b2b first", 8'hC1, acc_a, dc_a, 1'b0, n);
      $display("cmd b2b first: accept@%0d done@%0d writes=%0d", acc_a, dc_a, n);
      build_expected(5, 41, 6, 2);
      fill_exp_mem(5, 41, 6, 2, 8'h07);
      start_cmd("b2b second", 5, 41, 6, 2, 8'h07, 1'b0, acc_b);
      check("b2b second accept after done", 64'(acc_b - dc_a), 64'd1);
      wait_done("b2b second", dc_b);
      drain("b2b second", 8'h07, acc_b, dc_b, 1'b0, n);
      check_mem("b2b");
      $display("cmd b2b second: accept@%0d done@%0d writes=%0d", acc_b, dc_b, n);

      for (int t = 0; t < 16; t++) begin
         rx = $urandom_range(0, 405);
         ry = $urandom_range(0, 305);
         rw = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 40);
         rh = $urandom_range(0, 6);
         rc = 8'($urandom());
         run_cmd($sformatf("random%0d", t), rx, ry, rw, rh, rc);
      end

      // Reset asserted mid-fill: the port must go quiet at once.
      build_expected(50, 50, 100, 100);
      start_cmd("abort", 50, 50, 100, 100, 8'hF0, 1'b0, acc_a);
      repeat (150) @(negedge clk);
      #2 resetn = 1'b0;
      #1;
      check("abort en", 64'(buffer_en), 64'd0);
      check("abort we", 64'(buffer_we), 64'd0);
      check("abort busy", 64'(busy), 64'd0);
      check("abort ready", 64'(cmd_ready), 64'd1);
      check("abort done", 64'(done), 64'd0);
      @(negedge clk);
      drain("abort", 8'hF0, acc_a, -1, 1'b1, n);
      check("abort writes before reset", 64'(n), 64'd150);
      apply_exp_prefix(n, 8'hF0);
      $display("cmd abort: accept@%0d writes before reset=%0d", acc_a, n);
      repeat (2) @(negedge clk);
      check("abort en held", 64'(buffer_en), 64'd0);
      resetn = 1'b1;
      repeat (3) @(negedge clk);
      check("post-reset no stray writes", 64'(mon_addr.size()), 64'd0);
      check_mem("abort");
      run_cmd("after reset 1x1", 77, 123, 1, 1, 8'h4B);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
